// File: rtl/fetch_pkg.sv
// Shared widths, reset address, FSM state type and prefetch-queue entry layout
// for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy count.
// The head output reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    count    = cnt;
    empty    = (cnt == '0);
    pop_data = (cnt != '0) ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order requests to memory, a prefetch
// queue towards decode, and redirect handling that drains stale responses.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned     XLEN     = fetch_pkg::XLEN,
  parameter int unsigned     DEPTH    = fetch_pkg::DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ILEN + XLEN;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   discard_nxt;
  logic [CW-1:0]   q_count;
  logic [CW:0]     in_use;
  logic            accept;
  logic            resp_ok;
  logic            q_push;
  logic            q_empty;
  logic [EW-1:0]   q_head;

  // In FETCH every in-flight request is live and the addresses are contiguous
  // up to fetch_pc, so the oldest one sits outstanding*4 bytes behind it.
  always_comb begin
    in_use        = {1'b0, q_count} + {1'b0, outstanding};
    mem_req_valid = rstn && (state == FETCH) && (in_use < CREDIT_LIMIT);
    accept        = mem_req_valid && mem_req_ready;
    resp_ok       = mem_resp_valid && (outstanding != '0);
    resp_pc       = fetch_pc - (XLEN'(outstanding) << 2);
    q_push        = resp_ok && (state == FETCH) && !redirect_valid;
    mem_req_addr  = fetch_pc;
  end

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;

    case ({accept, resp_ok})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: ;
    endcase

    if (accept)         fetch_pc_nxt = fetch_pc + XLEN'(4);
    if (redirect_valid) fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          discard_nxt = outstanding_nxt;
          if (outstanding_nxt != '0) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (resp_ok) discard_nxt = discard - CW'(1);
        if (discard_nxt == '0) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data ({mem_resp_data, resp_pc}),
    .pop       (instr_ready),
    .pop_data  (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  always_comb begin
    instr_valid = !q_empty;
    instr       = q_head[EW-1 -: ILEN];
    instr_pc    = q_head[XLEN-1:0];
  end

  resp_without_request: assert property (
    @(posedge clk) disable iff (!rstn) !(mem_resp_valid && (outstanding == '0))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of requests, in-flight fetches and the queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH_T = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  fetch_unit #(
    .XLEN     (64),
    .DEPTH    (DEPTH_T),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; bit drop; } flight_t;
  typedef struct { int unsigned due; logic [31:0] data; } mresp_t;

  flight_t      inflight[$];
  fetch_entry_t iq[$];
  mresp_t       mq[$];
  logic [63:0]  m_pc;
  int unsigned  cyc;
  int unsigned  lat;
  int unsigned  last_due;
  bit           fixed_data;
  int           n_cmp = 0;
  int           n_bad = 0;

  bit           obs_rv, obs_iv, obs_acc;
  logic [63:0]  obs_addr, obs_ipc;
  logic [31:0]  obs_instr;
  int unsigned  obs_cyc;

  function automatic bit model_req_valid();
    bit flushing = 1'b0;
    foreach (inflight[i]) if (inflight[i].drop) flushing = 1'b1;
    return !flushing && ((iq.size() + inflight.size()) < int'(DEPTH_T));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare, drive inputs, advance the model, move to next negedge.
  task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [63:0] rpc);
    bit           exp_rv, acc, cons, resp;
    logic [31:0]  rdata;
    fetch_entry_t e;
    flight_t      f;
    mresp_t       m;
    int unsigned  due;
    #1;
    exp_rv    = model_req_valid();
    obs_rv    = mem_req_valid;
    obs_addr  = mem_req_addr;
    obs_iv    = instr_valid;
    obs_ipc   = instr_pc;
    obs_instr = instr;
    obs_cyc   = cyc;
    chk("req_valid", 64'(mem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", mem_req_addr, m_pc);
    chk("instr_valid", 64'(instr_valid), 64'(iq.size() != 0));
    if (iq.size() != 0) begin
      chk("instr", 64'(instr), 64'(iq[0].instr));
      chk("instr_pc", instr_pc, iq[0].pc);
    end
    acc     = exp_rv && rdy;
    obs_acc = mem_req_valid && rdy;
    cons    = (iq.size() != 0) && irdy;
    resp    = 1'b0;
    if (mq.size() != 0) resp = (mq[0].due <= cyc);
    rdata   = resp ? mq[0].data : $urandom();
    mem_req_ready  = rdy;
    instr_ready    = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_resp_valid = resp;
    mem_resp_data  = rdata;
    if (cons) void'(iq.pop_front());
    if (resp) begin
      f = inflight.pop_front();
      void'(mq.pop_front());
      if (!f.drop && !redir) begin
        e.instr = rdata;
        e.pc    = f.pc;
        iq.push_back(e);
      end
    end
    if (acc) begin
      f.pc   = m_pc;
      f.drop = 1'b0;
      inflight.push_back(f);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.due  = due;
      m.data = fixed_data ? 32'h0000_0013 : $urandom();
      mq.push_back(m);
      m_pc = m_pc + 64'd4;
    end
    if (redir) begin
      iq.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
      m_pc = {rpc[63:2], 2'b00};
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) #2;
    rstn           = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    inflight.delete();
    iq.delete();
    mq.delete();
    m_pc = 64'h0;
    @(negedge clk);
    @(negedge clk);
    rstn     = 1'b1;
    cyc      = 0;
    last_due = 0;
  endtask

  task automatic quiesce();
    for (int k = 0; k < 40; k++) begin
      if (inflight.size() == 0 && iq.size() == 0) break;
      step(1'b0, 1'b1, 1'b0, '0);
    end
    chk("quiesce_timeout", 64'(inflight.size() + iq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_acc;
    bit          found_req, found_iv;
    logic [63:0] e_addr [3];
    int          n_e;
    bit          rdy, irdy, redir;
    logic [63:0] rpc;

    lat        = 1;
    fixed_data = 1'b1;
    cyc        = 0;
    last_due   = 0;
    do_reset(1'b0);

    // Streaming with 1-cycle memory: first instruction two cycles after first accept.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (k == 0) begin
        chk("a_first_req_valid", 64'(obs_rv), 64'd1);
        chk("a_first_addr", obs_addr, 64'h0);
      end
      if (k == 1) chk("a_iv_cycle1", 64'(obs_iv), 64'd0);
      if (k >= 2) begin
        chk("a_iv", 64'(obs_iv), 64'd1);
        chk("a_pc", obs_ipc, 64'(k - 2) * 64'd4);
        chk("a_instr", 64'(obs_instr), 64'h13);
      end
    end

    // Redirect coinciding with a response and a consume.
    step(1'b1, 1'b1, 1'b1, 64'h200);
    chk("d_iv_at_redirect", 64'(obs_iv), 64'd1);
    chk("d_pc_at_redirect", obs_ipc, 64'h18);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("d_iv_after_redirect", 64'(obs_iv), 64'd0);
    found_req = 1'b0;
    for (int k = 0; k < 10 && !found_req; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (obs_rv) begin
        found_req = 1'b1;
        chk("d_redirect_addr", obs_addr, 64'h200);
      end
    end
    chk("d_req_timeout", 64'(found_req), 64'd1);

    // Decode stalled: credit limit caps requests at the queue depth.
    do_reset(1'b0);
    lat   = 1;
    n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (obs_acc) n_acc++;
    end
    chk("b_accepts", 64'(n_acc), 64'd4);
    chk("b_req_valid_stalled", 64'(obs_rv), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("b_iv", 64'(obs_iv), 64'd1);
      chk("b_order", obs_ipc, 64'(k) * 64'd4);
    end
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, '0);
    chk("b_full_before_reset", 64'(obs_iv), 64'd1);
    do_reset(1'b1);

    // Redirect with three requests in flight on a 5-cycle memory.
    lat = 5;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 64'h1003);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("c_no_req_in_flush", 64'(obs_rv), 64'd0);
    found_req = 1'b0;
    found_iv  = 1'b0;
    for (int k = 0; k < 30 && !found_iv; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (obs_rv && !found_req) begin
        found_req = 1'b1;
        chk("c_req_addr", obs_addr, 64'h1000);
        chk("c_req_cycle", 64'(obs_cyc), 64'd8);
      end
      if (obs_iv) begin
        found_iv = 1'b1;
        chk("c_first_pc", obs_ipc, 64'h1000);
      end
    end
    chk("c_req_timeout", 64'(found_req), 64'd1);
    chk("c_iv_timeout", 64'(found_iv), 64'd1);

    // Address wrap at the top of the address space.
    lat = 1;
    quiesce();
    step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    n_e = 0;
    for (int k = 0; k < 10 && n_e < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (obs_acc) begin
        e_addr[n_e] = obs_addr;
        n_e++;
      end
    end
    chk("e_accept_count", 64'(n_e), 64'd3);
    if (n_e == 3) begin
      chk("e_addr0", e_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("e_addr1", e_addr[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("e_addr2", e_addr[2], 64'h0);
    end

    // Asynchronous reset while draining after a redirect.
    quiesce();
    lat = 5;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 64'h3000);
    step(1'b1, 1'b1, 1'b0, '0);
    do_reset(1'b1);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("f_req_after_reset", 64'(obs_rv), 64'd1);
    chk("f_addr_after_reset", obs_addr, 64'h0);

    // Randomized traffic.
    do_reset(1'b0);
    fixed_data = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) lat = $urandom_range(1, 4);
      if (i == 1500) do_reset(1'b1);
      rdy   = ($urandom_range(0, 3) != 0);
      irdy  = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        1:       rpc = {$urandom(), $urandom()};
        default: rpc = 64'($urandom_range(0, 32'hFFFF));
      endcase
      step(rdy, irdy, redir, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: XLEN, 64, address/PC width; DEPTH, 4, prefetch queue entries (power of 2, >=2); RESET_PC, 0, first fetch address.
REQ-002 SHALL have port: clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: mem_req_valid  out  1  fetch request valid.
REQ-005 SHALL have port: mem_req_ready  in  1  memory accepts request this cycle.
REQ-006 SHALL have port: mem_req_addr  out  XLEN  word-aligned fetch address.
REQ-007 SHALL have port: mem_resp_valid  in  1  response data valid; in order, no backpressure.
REQ-008 SHALL have port: mem_resp_data  in  32  fetched instruction word.
REQ-009 SHALL have port: instr_valid  out  1  queue head valid to decode stage.
REQ-010 SHALL have port: instr_ready  in  1  decode stage consumes head this cycle.
REQ-011 SHALL have port: instr  out  32  instruction at queue head.
REQ-012 SHALL have port: instr_pc  out  XLEN  address of instr.
REQ-013 SHALL have port: redirect_valid  in  1  branch taken/redirect, single-cycle pulse.
REQ-014 SHALL have port: redirect_pc  in  XLEN  new fetch target.

Function
REQ-015 Request accepted when mem_req_valid && mem_req_ready; consumed when instr_valid && instr_ready.
REQ-016 SHALL hold fetch_pc register; on each accepted request fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFF_FFFF_FFFF_FFFC -> 0).
REQ-017 mem_req_addr SHALL equal fetch_pc; mem_req_valid/mem_req_addr stable until accepted.
REQ-018 Credit rule: mem_req_valid SHALL be 1 only in state FETCH and when queue_count + outstanding < DEPTH; queue never overflows.
REQ-019 outstanding counter (0..DEPTH) SHALL +1 on accept, -1 on mem_resp_valid, unchanged when both.
REQ-020 Non-discarded response SHALL push {mem_resp_data, pc} into queue; instr_valid rises the cycle after the response cycle (queue write registered).
REQ-021 instr_valid SHALL equal queue non-empty; instr/instr_pc from head; push and pop may occur same cycle, including full queue only with simultaneous pop.
REQ-022 Sustained throughput SHALL be one instruction/cycle with 1-cycle memory and instr_ready held high.
REQ-023 FSM states FETCH, FLUSH. On redirect_valid: queue emptied, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, discard <= responses still in flight (including a request accepted that same cycle, excluding a response arriving that same cycle, which is itself dropped); next state FLUSH if discard > 0 else FETCH.
REQ-024 In FLUSH: no requests; each mem_resp_valid decrements discard and is dropped; FLUSH -> FETCH on the cycle discard reaches 0.
REQ-025 Redirect in FLUSH SHALL update fetch_pc and remain in FLUSH; discard unchanged apart from that cycle's response decrement.
REQ-026 Redirect concurrent with consume: consume completes, then queue flushed; instr_valid is 0 the cycle after any redirect.
REQ-027 mem_resp_valid with outstanding==0 is a protocol error; SHALL be ignored, flagged by assertion.

Reset
REQ-028 While rstn==0: state FETCH, fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-029 First request (addr RESET_PC) SHALL be presented in the first cycle after rstn release; reset mid-operation discards all state; responses after reset to pre-reset requests are the environment's responsibility.

Structure
REQ-030 Package fetch_pkg SHALL hold XLEN, ILEN=32, default DEPTH, RESET_PC, fetch_state_t enum {FETCH, FLUSH}, and a queue-entry struct {instr, pc}.
REQ-031 Queue SHALL be sub-module sync_fifo (parameterised width/depth, flush input, count output); fetch_unit holds FSM, counters, fetch_pc.

Verification
REQ-032 Reset release, 1-cycle memory returning 0x00000013, instr_ready=1 -> instrs at pc 0x0,0x4,0x8... one per cycle, first instr_valid 2 cycles after first accept.
REQ-033 instr_ready=0, DEPTH=4 -> exactly 4 accepts, mem_req_valid then 0; queue holds pc 0x0..0xC in order.
REQ-034 Redirect to 0x1003 with 3 outstanding, 5-cycle memory -> FLUSH, 3 responses dropped, next request addr 0x1000, first instr_pc 0x1000.
REQ-035 Redirect same cycle as response and a consume -> consumed instr delivered once, response dropped, instr_valid 0 next cycle.
REQ-036 fetch_pc redirected to 0xFFFF_FFFF_FFFF_FFF8 -> requests 0x...FFF8, 0x...FFFC, 0x0.
REQ-037 rstn asserted mid-FLUSH -> all outputs at REQ-028 values immediately (asynchronous), request at RESET_PC after release.
